// File: rtl/dly_calib_defs.sv
// Shared definitions for the delay-line calibration sequencer: state encoding,
// default widths and the power-on calibration settings.
package dly_calib_defs;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CH_W     = 2;
  localparam int DEF_PULSE_W  = 5;
  localparam int DEF_PERIOD_W = 4;

  localparam int DEF_NUM_PULSE = 25;
  localparam int DEF_PERIOD    = 8;
  localparam int DEF_HIGH      = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dly_pulse_timer.sv
// Free-running phase counter over one calibration pulse period. The flags
// describe the phase that will be current after the next edge.
module dly_pulse_timer #(
  parameter int PERIOD_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] high,
  output logic                period_end,
  output logic                high_next
);

  logic [PERIOD_W-1:0] phase_reg;
  logic [PERIOD_W-1:0] phase_next;

  assign period_end = (phase_reg == (period - PERIOD_W'(1)));

  always_comb begin
    phase_next = phase_reg + PERIOD_W'(1);
    if (clr || period_end) begin
      phase_next = '0;
    end
  end

  // Lets the parent register calib for the coming phase without extra delay.
  assign high_next = (phase_next < high);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/dly_calib_seq.sv
// Delay-line calibration pulse sequencer: programmable pulse trains to the TDC
// groups, broadcast or one channel at a time, with status back to the top FSM.
module dly_calib_seq
  import dly_calib_defs::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CH_W     = DEF_CH_W,
  parameter int PULSE_W  = DEF_PULSE_W,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk_div_enable,
  input  logic                rst_n,
  input  logic                cs_dly_calib,
  input  logic [PULSE_W-1:0]  cfg_num_pulse,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_high,
  input  logic [NUM_CH-1:0]   cfg_ch_mask,
  input  logic                cfg_seq_mode,
  output logic [NUM_CH-1:0]   calib_dly,
  output logic                busy,
  output logic                finish_dly_calib,
  output logic                err_cfg,
  output logic [PULSE_W-1:0]  cnt_pulse,
  output logic [CH_W-1:0]     cur_ch
);

  // {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask, input int from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        res = {1'b1, CH_W'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  state_t               state_reg, state_next;
  logic [NUM_CH-1:0]    calib_reg, calib_next;
  logic                 busy_reg, busy_next;
  logic                 finish_reg, finish_next;
  logic                 err_reg, err_next;
  logic [PULSE_W-1:0]   cnt_reg, cnt_next;
  logic [CH_W-1:0]      cur_reg, cur_next;

  logic [PULSE_W-1:0]   num_lat_reg, num_lat_next;
  logic [PERIOD_W-1:0]  period_lat_reg, period_lat_next;
  logic [PERIOD_W-1:0]  high_lat_reg, high_lat_next;
  logic [NUM_CH-1:0]    mask_lat_reg, mask_lat_next;
  logic                 seq_lat_reg, seq_lat_next;

  logic                 period_end;
  logic                 high_next;
  logic                 cfg_valid;
  logic [PULSE_W-1:0]   cnt_inc;
  logic [CH_W:0]        first_ch;
  logic [CH_W:0]        next_ch;
  logic [NUM_CH-1:0]    active;

  dly_pulse_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk        (clk_div_enable),
    .rst_n      (rst_n),
    .clr        (state_reg != ST_RUN),
    .period     (period_lat_reg),
    .high       (high_lat_reg),
    .period_end (period_end),
    .high_next  (high_next)
  );

  // high >= period also rejects period == 0.
  assign cfg_valid = (cfg_num_pulse != '0) && (cfg_high != '0) &&
                     (cfg_high < cfg_period) && (cfg_ch_mask != '0);

  assign cnt_inc  = cnt_reg + PULSE_W'(1);
  assign first_ch = find_ch(cfg_ch_mask, 0);
  assign next_ch  = find_ch(mask_lat_reg, int'(cur_reg) + 1);

  always_comb begin
    state_next      = state_reg;
    calib_next      = calib_reg;
    busy_next       = busy_reg;
    finish_next     = finish_reg;
    err_next        = err_reg;
    cnt_next        = cnt_reg;
    cur_next        = cur_reg;
    num_lat_next    = num_lat_reg;
    period_lat_next = period_lat_reg;
    high_lat_next   = high_lat_reg;
    mask_lat_next   = mask_lat_reg;
    seq_lat_next    = seq_lat_reg;
    active          = '0;

    if (!cs_dly_calib) begin
      // Abort or idle: everything but the error flag clears.
      state_next  = ST_IDLE;
      calib_next  = '0;
      busy_next   = 1'b0;
      finish_next = 1'b0;
      cnt_next    = '0;
      cur_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          num_lat_next    = cfg_num_pulse;
          period_lat_next = cfg_period;
          high_lat_next   = cfg_high;
          mask_lat_next   = cfg_ch_mask;
          seq_lat_next    = cfg_seq_mode;
          cnt_next        = '0;
          if (!cfg_valid) begin
            state_next  = ST_DONE;
            calib_next  = '0;
            busy_next   = 1'b0;
            finish_next = 1'b1;
            err_next    = 1'b1;
            cur_next    = '0;
          end else begin
            // A valid config always has high >= 1, so phase 0 is a high phase.
            state_next  = ST_RUN;
            busy_next   = 1'b1;
            finish_next = 1'b0;
            err_next    = 1'b0;
            cur_next    = cfg_seq_mode ? first_ch[CH_W-1:0] : '0;
            calib_next  = cfg_seq_mode ? onehot(first_ch[CH_W-1:0]) : cfg_ch_mask;
          end
        end

        ST_RUN: begin
          if (period_end) begin
            if (cnt_inc == num_lat_reg) begin
              if (seq_lat_reg && next_ch[CH_W]) begin
                cur_next = next_ch[CH_W-1:0];
                cnt_next = '0;
              end else begin
                state_next  = ST_DONE;
                busy_next   = 1'b0;
                finish_next = 1'b1;
                cnt_next    = cnt_inc;
              end
            end else begin
              cnt_next = cnt_inc;
            end
          end
          active     = seq_lat_reg ? onehot(cur_next) : mask_lat_reg;
          calib_next = ((state_next == ST_RUN) && high_next) ? active : '0;
        end

        ST_DONE: begin
          calib_next  = '0;
          busy_next   = 1'b0;
          finish_next = 1'b1;
        end

        default: begin
          state_next = ST_IDLE;
          calib_next = '0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_div_enable or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      calib_reg      <= '0;
      busy_reg       <= 1'b0;
      finish_reg     <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
      cur_reg        <= '0;
      num_lat_reg    <= '0;
      period_lat_reg <= '0;
      high_lat_reg   <= '0;
      mask_lat_reg   <= '0;
      seq_lat_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      calib_reg      <= calib_next;
      busy_reg       <= busy_next;
      finish_reg     <= finish_next;
      err_reg        <= err_next;
      cnt_reg        <= cnt_next;
      cur_reg        <= cur_next;
      num_lat_reg    <= num_lat_next;
      period_lat_reg <= period_lat_next;
      high_lat_reg   <= high_lat_next;
      mask_lat_reg   <= mask_lat_next;
      seq_lat_reg    <= seq_lat_next;
    end
  end

  assign calib_dly        = calib_reg;
  assign busy             = busy_reg;
  assign finish_dly_calib = finish_reg;
  assign err_cfg          = err_reg;
  assign cnt_pulse        = cnt_reg;
  assign cur_ch           = cur_reg;

endmodule

// File: tb/tb_dly_calib_seq.sv
// Scoreboard bench: the stimulus pushes per-edge expectations from a timeline
// model of the pulse train; a monitor compares them after every clock edge.
module tb_dly_calib_seq;

  logic       clk_div_enable = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_dly_calib = 1'b0;
  logic [4:0] cfg_num_pulse = '0;
  logic [3:0] cfg_period = '0;
  logic [3:0] cfg_high = '0;
  logic [3:0] cfg_ch_mask = '0;
  logic       cfg_seq_mode = 1'b0;
  logic [3:0] calib_dly;
  logic       busy;
  logic       finish_dly_calib;
  logic       err_cfg;
  logic [4:0] cnt_pulse;
  logic [1:0] cur_ch;

  typedef struct packed {
    logic [4:0] num;
    logic [3:0] period;
    logic [3:0] high;
    logic [3:0] mask;
    logic       seq;
  } cfg_t;

  typedef struct packed {
    logic [3:0] calib;
    logic       busy;
    logic       finish;
    logic       err;
    logic [4:0] cnt;
    logic [1:0] cur;
  } obs_t;

  typedef struct packed {
    int   stamp;
    obs_t v;
  } item_t;

  item_t exp_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  bit    running = 1'b0;
  int    e_idx = 0;
  cfg_t  lat;
  logic  last_err = 1'b0;

  dly_calib_seq #(
    .NUM_CH(4), .CH_W(2), .PULSE_W(5), .PERIOD_W(4)
  ) dut (
    .clk_div_enable   (clk_div_enable),
    .rst_n            (rst_n),
    .cs_dly_calib     (cs_dly_calib),
    .cfg_num_pulse    (cfg_num_pulse),
    .cfg_period       (cfg_period),
    .cfg_high         (cfg_high),
    .cfg_ch_mask      (cfg_ch_mask),
    .cfg_seq_mode     (cfg_seq_mode),
    .calib_dly        (calib_dly),
    .busy             (busy),
    .finish_dly_calib (finish_dly_calib),
    .err_cfg          (err_cfg),
    .cnt_pulse        (cnt_pulse),
    .cur_ch           (cur_ch)
  );

  always #5 clk_div_enable = ~clk_div_enable;
  always @(posedge clk_div_enable) cyc <= cyc + 1;

  function automatic bit cfg_ok(input cfg_t c);
    return (c.num != 0) && (c.high != 0) && (c.high < c.period) && (c.mask != 0);
  endfunction

  function automatic int popcnt(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic int run_len(input cfg_t c);
    if (!cfg_ok(c)) return 1;
    return int'(c.num) * int'(c.period) * (c.seq ? popcnt(c.mask) : 1);
  endfunction

  // Outputs seen after edge e of a run (e = 0 is the start edge).
  function automatic obs_t model_at(input cfg_t c, input int e);
    obs_t x;
    int   chans[$];
    int   per_ch, total, ci, w;
    x = '0;
    if (!cfg_ok(c)) begin
      x.finish = 1'b1;
      x.err    = 1'b1;
      return x;
    end
    for (int i = 0; i < 4; i++) if (c.mask[i]) chans.push_back(i);
    per_ch = int'(c.num) * int'(c.period);
    total  = run_len(c);
    if (e >= total) begin
      x.finish = 1'b1;
      x.cnt    = c.num;
      x.cur    = c.seq ? 2'(chans[chans.size() - 1]) : 2'd0;
      return x;
    end
    ci     = c.seq ? (e / per_ch) : 0;
    w      = c.seq ? (e % per_ch) : e;
    x.busy = 1'b1;
    x.cnt  = 5'(w / int'(c.period));
    x.cur  = c.seq ? 2'(chans[ci]) : 2'd0;
    if ((w % int'(c.period)) < int'(c.high)) begin
      x.calib = c.seq ? (4'b0001 << chans[ci]) : c.mask;
    end
    return x;
  endfunction

  // Called at a falling edge: drives inputs for the next rising edge and queues what it must produce.
  task automatic step(input logic cs_v, input logic rst_v);
    obs_t  x;
    item_t it;
    cs_dly_calib = cs_v;
    rst_n        = rst_v;
    x = '0;
    if (!rst_v) begin
      running  = 1'b0;
      last_err = 1'b0;
    end else if (!cs_v) begin
      running = 1'b0;
      x.err   = last_err;
    end else begin
      if (!running) begin
        running = 1'b1;
        e_idx   = 0;
        lat     = {cfg_num_pulse, cfg_period, cfg_high, cfg_ch_mask, cfg_seq_mode};
      end else begin
        e_idx++;
        cfg_num_pulse = 5'($urandom);
        cfg_period    = 4'($urandom);
        cfg_high      = 4'($urandom);
        cfg_ch_mask   = 4'($urandom);
        cfg_seq_mode  = 1'($urandom);
      end
      x        = model_at(lat, e_idx);
      last_err = x.err;
    end
    it.stamp = cyc + 1;
    it.v     = x;
    exp_q.push_back(it);
    @(negedge clk_div_enable);
  endtask

  task automatic run(input cfg_t c, input int n);
    cfg_num_pulse = c.num;
    cfg_period    = c.period;
    cfg_high      = c.high;
    cfg_ch_mask   = c.mask;
    cfg_seq_mode  = c.seq;
    repeat (n) step(1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  // Monitor
  initial begin
    item_t it;
    obs_t  got;
    forever begin
      @(posedge clk_div_enable);
      #1;
      while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        it  = exp_q.pop_front();
        got = {calib_dly, busy, finish_dly_calib, err_cfg, cnt_pulse, cur_ch};
        n_cmp++;
        if (got !== it.v) begin
          n_bad++;
          $display("FAIL obs cyc=%0d got calib=%b busy=%b fin=%b err=%b cnt=%0d cur=%0d want calib=%b busy=%b fin=%b err=%b cnt=%0d cur=%0d",
                   cyc, got.calib, got.busy, got.finish, got.err, got.cnt, got.cur,
                   it.v.calib, it.v.busy, it.v.finish, it.v.err, it.v.cnt, it.v.cur);
        end
      end
    end
  end

  // Stimulus
  initial begin
    cfg_t c1, c2, c3, cbad, cgood, cr;
    int   len, n;
    c1    = '{num: 5'd25, period: 4'd8, high: 4'd1, mask: 4'b0001, seq: 1'b0};
    c2    = '{num: 5'd3,  period: 4'd4, high: 4'd2, mask: 4'b0101, seq: 1'b1};
    c3    = '{num: 5'd2,  period: 4'd3, high: 4'd1, mask: 4'b1111, seq: 1'b0};
    cbad  = '{num: 5'd4,  period: 4'd8, high: 4'd8, mask: 4'b0011, seq: 1'b0};
    cgood = '{num: 5'd2,  period: 4'd5, high: 4'd3, mask: 4'b1010, seq: 1'b1};

    @(negedge clk_div_enable);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    run(c1, 205);  idle(1);
    run(c2, 28);   idle(2);
    run(c3, 9);    idle(1);
    run(cbad, 3);  idle(1);
    run(cgood, 24); idle(1);

    // abort at edge 10 then a full rerun
    run(c1, 10);   idle(1);
    run(c1, 204);  idle(1);

    // asynchronous reset in the middle of a run
    run(c3, 4);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({calib_dly, busy, finish_dly_calib, err_cfg, cnt_pulse, cur_ch} !== 14'd0) begin
      n_bad++;
      $display("FAIL async_rst got calib=%b busy=%b fin=%b err=%b cnt=%0d cur=%0d want all zero",
               calib_dly, busy, finish_dly_calib, err_cfg, cnt_pulse, cur_ch);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(c3, 9);    idle(1);

    for (int k = 0; k < 40; k++) begin
      cr.num    = 5'($urandom_range(0, 6));
      cr.period = 4'($urandom_range(0, 7));
      cr.high   = 4'($urandom_range(0, 4));
      cr.mask   = 4'($urandom_range(0, 15));
      cr.seq    = 1'($urandom_range(0, 1));
      len = run_len(cr);
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : len + int'($urandom_range(0, 3));
      run(cr, n);
      idle(int'($urandom_range(1, 2)));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk_div_enable);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
